// File: rtl/hilo_mult_sequencer.sv
// HI/LO multi-cycle sequencer: iterative shift-add mult/multu/madd/msub plus mthi/mtlo.
// Optional feature macro: HILO_BYPASS_EN (forward the value being written during WRITE
// onto Hi/Lo and let RdReq through without a stall in that cycle).
module hilo_mult_sequencer #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [4:0]       ALUCtl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             RdReq,
    input  logic             Flush,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Stall,
    output logic             Done
);

    localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    localparam logic [4:0] OP_MULT  = 5'b00101;
    localparam logic [4:0] OP_MULTU = 5'b01100;
    localparam logic [4:0] OP_MADD  = 5'b11010;
    localparam logic [4:0] OP_MSUB  = 5'b01101;
    localparam logic [4:0] OP_MTHI  = 5'b10001;
    localparam logic [4:0] OP_MTLO  = 5'b10011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               done_next;

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               sign_q;
    logic               op_add;
    logic               op_sub;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               is_mult;
    logic               is_multu;
    logic               is_madd;
    logic               is_msub;
    logic               is_mthi;
    logic               is_mtlo;
    logic               is_mul_class;
    logic               is_signed;
    logic               take;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [ACC_W-1:0]   partial;
    logic [ACC_W-1:0]   prod;
    logic [ACC_W-1:0]   hilo_cur;
    logic [ACC_W-1:0]   hilo_new;

    // Opcode decode and operand magnitude for the signed ops
    always_comb begin
        is_mult      = (ALUCtl == OP_MULT);
        is_multu     = (ALUCtl == OP_MULTU);
        is_madd      = (ALUCtl == OP_MADD);
        is_msub      = (ALUCtl == OP_MSUB);
        is_mthi      = (ALUCtl == OP_MTHI);
        is_mtlo      = (ALUCtl == OP_MTLO);
        is_signed    = is_mult | is_madd | is_msub;
        is_mul_class = is_signed | is_multu;
        take         = (state == S_IDLE) && Start && !Flush;
        abs_a        = (is_signed && A[WIDTH-1]) ? WIDTH'(-A) : A;
        abs_b        = (is_signed && B[WIDTH-1]) ? WIDTH'(-B) : B;
    end

    // Shifted-multiplicand contributions of the low BITS_PER_CYCLE multiplier bits
    always_comb begin
        partial = '0;
        for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
            if (mplier[j]) begin
                partial = partial + (mcand << j);
            end
        end
    end

    // Sign fix-up and HI/LO accumulate for the WRITE cycle
    always_comb begin
        prod     = sign_q ? ACC_W'(-acc) : acc;
        hilo_cur = {hi_q, lo_q};
        if (op_add) begin
            hilo_new = hilo_cur + prod;
        end else if (op_sub) begin
            hilo_new = hilo_cur - prod;
        end else begin
            hilo_new = prod;
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and Done pulse; Flush always returns to IDLE without a Done
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (take && is_mul_class) begin
                    state_next = S_RUN;
                end
                if (take && (is_mthi || is_mtlo)) begin
                    done_next = 1'b1;
                end
            end
            S_RUN: begin
                if (Flush) begin
                    state_next = S_IDLE;
                end else if (cnt == '0) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                state_next = S_IDLE;
                done_next  = !Flush;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand latch, iterative accumulate, HI/LO update
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            op_add <= 1'b0;
            op_sub <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_next;
            case (state)
                S_IDLE: begin
                    if (take && is_mul_class) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, abs_a};
                        mplier <= abs_b;
                        cnt    <= CNT_W'(N - 1);
                        sign_q <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        op_add <= is_madd;
                        op_sub <= is_msub;
                    end
                    if (take && is_mthi) begin
                        hi_q <= A;
                    end
                    if (take && is_mtlo) begin
                        lo_q <= A;
                    end
                end
                S_RUN: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt - CNT_W'(1);
                end
                S_WRITE: begin
                    if (!Flush) begin
                        {hi_q, lo_q} <= hilo_new;
                    end
                end
                default: begin
                end
            endcase
            if (Flush) begin
                cnt <= '0;
            end
        end
    end

    assign Busy = (state != S_IDLE);
    assign Done = done_q;

`ifdef HILO_BYPASS_EN
    logic bypass;
    assign bypass = (state == S_WRITE) && !Flush;
    assign Hi     = bypass ? hilo_new[ACC_W-1:WIDTH] : hi_q;
    assign Lo     = bypass ? hilo_new[WIDTH-1:0]     : lo_q;
    assign Stall  = Busy && (Start || (RdReq && (state != S_WRITE)));
`else
    assign Hi     = hi_q;
    assign Lo     = lo_q;
    assign Stall  = Busy && (Start || RdReq);
`endif

endmodule
